// File: rtl/sd_model_loader.sv
// sd_model_loader: sequences multi-sector model loads from the SD card.
// It requests one sector at a time from the single-sector SPI read engine.
// It packs the engine's 16-bit stream into 32-bit little-endian words.
// The words go through a small FIFO to an on-chip memory write port.
//
// Ports:
//   clk_ref, rst           clock and asynchronous active-high reset
//   init_done, start       SD ready / one-cycle load request
//   start_sector,
//   sector_cnt, dst_addr   load parameters, latched on an accepted start
//   busy, done             load in progress / one-cycle completion pulse
//   err_ovf, err_len       sticky errors: FIFO overflow / bad sector length
//   rd_start_en,
//   rd_sec_addr            level request and sector address to the read engine
//   rd_busy, rd_val_en,
//   rd_val_data            read engine status and halfword stream
//   mem_wr_en,
//   mem_wr_ready,
//   mem_wr_addr,
//   mem_wr_data            memory write port (valid/ready)
module sd_model_loader #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned SEC_CNT_W  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk_ref,
  input  logic                 rst,
  input  logic                 init_done,
  input  logic                 start,
  input  logic [31:0]          start_sector,
  input  logic [SEC_CNT_W-1:0] sector_cnt,
  input  logic [ADDR_W-1:0]    dst_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 err_ovf,
  output logic                 err_len,
  output logic                 rd_start_en,
  output logic [31:0]          rd_sec_addr,
  input  logic                 rd_busy,
  input  logic                 rd_val_en,
  input  logic [15:0]          rd_val_data,
  output logic                 mem_wr_en,
  input  logic                 mem_wr_ready,
  output logic [ADDR_W-1:0]    mem_wr_addr,
  output logic [31:0]          mem_wr_data
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned HW_W  = 9;
  localparam logic [HW_W-1:0] HW_PER_SEC = HW_W'(256);
  localparam logic [HW_W-1:0] HW_MAX     = HW_W'(511);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    XFER  = 3'd2,
    NEXT  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t state;
  state_t next_state;
  logic   busy_d;
  logic   rd_start_en_d;
  logic   done_d;

  logic                 accept_start;
  logic [31:0]          cur_sector;
  logic [SEC_CNT_W-1:0] remaining;
  logic [HW_W-1:0]      hw_cnt;
  logic [HW_W-1:0]      hw_cnt_nxt;

  // Packing stage: h0 holds the first halfword of a pair, word/word_vld is the push request
  logic                 phase;
  logic [15:0]          h0;
  logic [31:0]          word;
  logic                 word_vld;
  logic [ADDR_W-1:0]    push_addr;

  // Shift-register FIFO: entry 0 is always the head, so the write port comes straight from flops
  logic [31:0]          fifo_dat   [FIFO_DEPTH];
  logic [31:0]          fifo_dat_n [FIFO_DEPTH];
  logic [ADDR_W-1:0]    fifo_adr   [FIFO_DEPTH];
  logic [ADDR_W-1:0]    fifo_adr_n [FIFO_DEPTH];
  logic [CNT_W-1:0]     fifo_cnt;
  logic [CNT_W-1:0]     fifo_cnt_n;
  logic [CNT_W-1:0]     wr_idx;
  logic                 pop;
  logic                 full;
  logic                 push_ok;
  logic                 drop;
  logic                 fifo_empty;

  assign accept_start = (state == IDLE) && start && init_done;
  assign rd_sec_addr  = cur_sector;
  assign mem_wr_data  = fifo_dat[0];
  assign mem_wr_addr  = fifo_adr[0];

  // A strobe is only counted while a sector transfer is in flight; the count saturates
  always_comb begin
    hw_cnt_nxt = hw_cnt;
    if ((state == XFER) && rd_val_en && (hw_cnt != HW_MAX)) begin
      hw_cnt_nxt = hw_cnt + HW_W'(1);
    end
  end

  // State and registered control outputs
  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      rd_start_en <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= next_state;
      busy        <= busy_d;
      rd_start_en <= rd_start_en_d;
      done        <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept_start) begin
          next_state = (sector_cnt == '0) ? DRAIN : REQ;
        end
      end
      REQ: begin
        if (rd_busy) next_state = XFER;
      end
      XFER: begin
        if (!rd_busy) next_state = NEXT;
      end
      NEXT: begin
        next_state = (remaining == SEC_CNT_W'(1)) ? DRAIN : REQ;
      end
      DRAIN: begin
        if (fifo_empty) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output decode from the next state, so the registered outputs line up with the state
  always_comb begin
    busy_d        = 1'b0;
    rd_start_en_d = 1'b0;
    done_d        = 1'b0;
    busy_d        = (next_state != IDLE);
    rd_start_en_d = (next_state == REQ);
    done_d        = (state == DRAIN) && (next_state == IDLE);
  end

  // Sector sequencing, halfword packing and sticky errors
  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      cur_sector <= '0;
      remaining  <= '0;
      hw_cnt     <= '0;
      phase      <= 1'b0;
      h0         <= '0;
      word       <= '0;
      word_vld   <= 1'b0;
      push_addr  <= '0;
      err_ovf    <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      word_vld <= 1'b0;
      // Dropped words still consume an address so later data stays aligned
      if (word_vld) push_addr <= push_addr + ADDR_W'(1);
      if (drop) err_ovf <= 1'b1;
      if (state == XFER) begin
        hw_cnt <= hw_cnt_nxt;
        if (rd_val_en) begin
          if (!phase) begin
            h0 <= rd_val_data;
          end else begin
            // [15:8] is the earlier byte on the wire, so swap within each halfword
            word     <= {rd_val_data[7:0], rd_val_data[15:8], h0[7:0], h0[15:8]};
            word_vld <= 1'b1;
          end
          phase <= ~phase;
        end
        if (!rd_busy && (hw_cnt_nxt != HW_PER_SEC)) err_len <= 1'b1;
      end
      if (state == NEXT) begin
        cur_sector <= cur_sector + 32'd1;
        remaining  <= remaining - SEC_CNT_W'(1);
        hw_cnt     <= '0;
        phase      <= 1'b0;
      end
      if (accept_start) begin
        cur_sector <= start_sector;
        remaining  <= sector_cnt;
        hw_cnt     <= '0;
        phase      <= 1'b0;
        push_addr  <= dst_addr;
        err_ovf    <= 1'b0;
        err_len    <= 1'b0;
      end
    end
  end

  // FIFO control: push and pop together on a full FIFO is not an overflow
  always_comb begin
    pop        = mem_wr_en && mem_wr_ready;
    full       = (fifo_cnt == CNT_W'(FIFO_DEPTH));
    push_ok    = word_vld && (!full || pop);
    drop       = word_vld && full && !pop;
    fifo_empty = (fifo_cnt == '0) && !word_vld;
    wr_idx     = fifo_cnt - CNT_W'(pop);
    fifo_cnt_n = fifo_cnt + CNT_W'(push_ok) - CNT_W'(pop);
  end

  // FIFO storage next-value: shift on pop, then write behind the last valid entry
  always_comb begin
    fifo_dat_n = fifo_dat;
    fifo_adr_n = fifo_adr;
    if (pop) begin
      for (int i = 0; i < int'(FIFO_DEPTH) - 1; i++) begin
        fifo_dat_n[i] = fifo_dat[i+1];
        fifo_adr_n[i] = fifo_adr[i+1];
      end
    end
    if (push_ok) begin
      fifo_dat_n[wr_idx[PTR_W-1:0]] = word;
      fifo_adr_n[wr_idx[PTR_W-1:0]] = push_addr;
    end
  end

  // FIFO registers
  always_ff @(posedge clk_ref or posedge rst) begin
    if (rst) begin
      fifo_dat  <= '{default: '0};
      fifo_adr  <= '{default: '0};
      fifo_cnt  <= '0;
      mem_wr_en <= 1'b0;
    end else begin
      fifo_dat  <= fifo_dat_n;
      fifo_adr  <= fifo_adr_n;
      fifo_cnt  <= fifo_cnt_n;
      mem_wr_en <= (fifo_cnt_n != '0);
    end
  end

endmodule

// File: tb/tb_sd_model_loader.sv
// Testbench for sd_model_loader: a behavioural SD read engine feeds sectors.
// The expected memory image is built from the sector bytes with plain arithmetic.
module tb_sd_model_loader;

  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned SEC_CNT_W  = 16;
  localparam int unsigned FIFO_DEPTH = 4;

  logic                 clk_ref = 1'b0;
  logic                 rst;
  logic                 init_done;
  logic                 start;
  logic [31:0]          start_sector;
  logic [SEC_CNT_W-1:0] sector_cnt;
  logic [ADDR_W-1:0]    dst_addr;
  logic                 busy;
  logic                 done;
  logic                 err_ovf;
  logic                 err_len;
  logic                 rd_start_en;
  logic [31:0]          rd_sec_addr;
  logic                 rd_busy;
  logic                 rd_val_en;
  logic [15:0]          rd_val_data;
  logic                 mem_wr_en;
  logic                 mem_wr_ready;
  logic [ADDR_W-1:0]    mem_wr_addr;
  logic [31:0]          mem_wr_data;

  always #5 clk_ref = ~clk_ref;

  sd_model_loader #(
    .ADDR_W     (ADDR_W),
    .SEC_CNT_W  (SEC_CNT_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_ref      (clk_ref),
    .rst          (rst),
    .init_done    (init_done),
    .start        (start),
    .start_sector (start_sector),
    .sector_cnt   (sector_cnt),
    .dst_addr     (dst_addr),
    .busy         (busy),
    .done         (done),
    .err_ovf      (err_ovf),
    .err_len      (err_len),
    .rd_start_en  (rd_start_en),
    .rd_sec_addr  (rd_sec_addr),
    .rd_busy      (rd_busy),
    .rd_val_en    (rd_val_en),
    .rd_val_data  (rd_val_data),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_ready (mem_wr_ready),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data)
  );

  int checks = 0;
  int errors = 0;

  // Sector contents (bytes in wire order) and halfwords delivered per sector
  logic [7:0]  stim [0:1535];
  int          hw_n [0:2];
  int          load_base = 0;
  int          served = 0;
  logic [31:0] sec_q [$];

  // Observed traffic
  logic [ADDR_W-1:0] wa_q [$];
  logic [31:0]       wd_q [$];
  int                done_cnt = 0;
  int                rs_cnt = 0;
  logic              rs_prev = 1'b0;
  int                wr_ptr = 0;
  logic [31:0]       exp_w [$];

  // Read engine model: level request in, busy window with one halfword per 16 cycles
  initial begin : engine
    int st, cnt_dn, i, k, idx;
    st = 0; cnt_dn = 0; i = 0; k = 0; idx = 0;
    rd_busy = 1'b0; rd_val_en = 1'b0; rd_val_data = '0;
    forever begin
      @(posedge clk_ref); #1;
      rd_val_en = 1'b0;
      if (rst) begin
        st = 0;
        rd_busy = 1'b0;
      end else begin
        case (st)
          0: if (rd_start_en) begin
            sec_q.push_back(rd_sec_addr);
            k = served - load_base;
            if (k > 2) k = 2;
            cnt_dn = 3;
            st = 1;
          end
          1: if (cnt_dn > 0) cnt_dn--;
             else begin rd_busy = 1'b1; i = 0; cnt_dn = 15; st = 2; end
          2: if (cnt_dn > 0) cnt_dn--;
             else if (i < hw_n[k]) begin
               idx = k * 512 + 2 * i;
               rd_val_en = 1'b1;
               rd_val_data = {stim[idx], stim[idx+1]};
               i++;
               cnt_dn = 15;
             end else begin
               cnt_dn = 4; st = 3;
             end
          3: if (cnt_dn > 0) cnt_dn--;
             else begin rd_busy = 1'b0; served++; st = 4; end
          default: if (!rd_start_en) st = 0;
        endcase
      end
    end
  end

  // Monitor away from the active edge
  always @(negedge clk_ref) begin
    if (mem_wr_en && mem_wr_ready) begin
      wa_q.push_back(mem_wr_addr);
      wd_q.push_back(mem_wr_data);
    end
    if (done) done_cnt++;
    if (rd_start_en && !rs_prev) rs_cnt++;
    rs_prev = rd_start_en;
  end

  task automatic tick();
    @(posedge clk_ref); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_counting();
    for (int j = 0; j < 1536; j++) stim[j] = 8'(j);
  endtask

  task automatic fill_random();
    for (int j = 0; j < 1536; j++) stim[j] = 8'($urandom);
  endtask

  // Memory image: byte 4w+n of a sector's stream lands in bits [8n+7:8n] of word w
  task automatic build_expected(input int nsec);
    int b;
    exp_w.delete();
    for (int s = 0; s < nsec; s++) begin
      for (int w = 0; w < hw_n[s] / 2; w++) begin
        b = s * 512 + 4 * w;
        exp_w.push_back({stim[b+3], stim[b+2], stim[b+1], stim[b]});
      end
    end
  endtask

  task automatic start_load(input logic [31:0] sec, input logic [SEC_CNT_W-1:0] cnt,
                            input logic [ADDR_W-1:0] dst);
    load_base = served;
    start_sector = sec;
    sector_cnt = cnt;
    dst_addr = dst;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0, input int budget);
    int n;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    repeat (5) tick();
    chk({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  task automatic check_writes(input string tag, input logic [ADDR_W-1:0] dst, input bit no_loss);
    int n, off, prev, bad_order, bad_range;
    logic [ADDR_W-1:0] offv;
    n = wd_q.size() - wr_ptr;
    prev = -1; bad_order = 0; bad_range = 0;
    for (int j = wr_ptr; j < wd_q.size(); j++) begin
      offv = wa_q[j] - dst;
      off = int'(offv);
      if (off <= prev) bad_order++;
      prev = off;
      if (off >= exp_w.size()) bad_range++;
      else chk($sformatf("%s_data@%0h", tag, wa_q[j]), wd_q[j], exp_w[off]);
    end
    chk({tag, "_order"}, 32'(bad_order), 32'd0);
    chk({tag, "_range"}, 32'(bad_range), 32'd0);
    if (no_loss) chk({tag, "_count"}, 32'(n), 32'(exp_w.size()));
    else chk({tag, "_lossy"}, 32'(n < exp_w.size()), 32'd1);
    wr_ptr = wd_q.size();
  endtask

  initial begin : stim_seq
    int d0, r0, s0, n;
    logic [ADDR_W-1:0] dst;
    rst = 1'b1; init_done = 1'b1; start = 1'b0; start_sector = '0;
    sector_cnt = '0; dst_addr = '0; mem_wr_ready = 1'b1;
    hw_n[0] = 256; hw_n[1] = 256; hw_n[2] = 256;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_start_en", 32'(rd_start_en), 32'd0);
    chk("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_mem_wr_addr", 32'(mem_wr_addr), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Single sector, counting bytes
    fill_counting();
    build_expected(1);
    d0 = done_cnt; s0 = sec_q.size();
    start_load(32'h100, 16'd1, 16'h20);
    chk("single_busy_t1", 32'(busy), 32'd1);
    chk("single_req_t1", 32'(rd_start_en), 32'd1);
    chk("single_sec_addr", rd_sec_addr, 32'h100);
    wait_done("single", d0, 4700);
    chk("single_first_addr", 32'(wa_q[wr_ptr]), 32'h20);
    chk("single_first_word", wd_q[wr_ptr], 32'h03020100);
    chk("single_last_addr", 32'(wa_q[wa_q.size()-1]), 32'h9F);
    check_writes("single", 16'h20, 1'b1);
    chk("single_err_ovf", 32'(err_ovf), 32'd0);
    chk("single_err_len", 32'(err_len), 32'd0);
    chk("single_sectors", 32'(sec_q.size() - s0), 32'd1);

    // Multi-sector with sector-address wrap and an ignored start while busy
    fill_random();
    build_expected(3);
    dst = 16'($urandom_range(0, 32'hF000));
    d0 = done_cnt; s0 = sec_q.size();
    start_load(32'hFFFF_FFFF, 16'd3, dst);
    repeat (200) tick();
    start_sector = 32'h1234; sector_cnt = 16'd5; dst_addr = 16'h0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_ignored", 32'(busy), 32'd1);
    wait_done("multi", d0, 13600);
    chk("multi_sectors", 32'(sec_q.size() - s0), 32'd3);
    chk("multi_sec0", sec_q[s0], 32'hFFFF_FFFF);
    chk("multi_sec1", sec_q[s0+1], 32'h0);
    chk("multi_sec2", sec_q[s0+2], 32'h1);
    check_writes("multi", dst, 1'b1);

    // Short first sector
    fill_random();
    hw_n[0] = 200;
    build_expected(2);
    dst = 16'($urandom_range(0, 32'hF000));
    d0 = done_cnt; s0 = sec_q.size();
    start_load($urandom, 16'd2, dst);
    wait_done("short", d0, 9200);
    hw_n[0] = 256;
    chk("short_err_len", 32'(err_len), 32'd1);
    chk("short_err_ovf", 32'(err_ovf), 32'd0);
    chk("short_sectors", 32'(sec_q.size() - s0), 32'd2);
    check_writes("short", dst, 1'b1);

    // Back-pressure within FIFO capacity; the new start clears err_len
    fill_random();
    build_expected(1);
    dst = 16'($urandom_range(0, 32'hF000));
    d0 = done_cnt;
    start_load($urandom, 16'd1, dst);
    chk("start_clears_err_len", 32'(err_len), 32'd0);
    repeat (2000) tick();
    mem_wr_ready = 1'b0;
    repeat (40) tick();
    mem_wr_ready = 1'b1;
    wait_done("bp40", d0, 4700);
    chk("bp40_err_ovf", 32'(err_ovf), 32'd0);
    check_writes("bp40", dst, 1'b1);

    // Long back-pressure overflows; surviving words keep their addresses
    fill_random();
    build_expected(1);
    dst = 16'($urandom_range(0, 32'hF000));
    d0 = done_cnt;
    start_load($urandom, 16'd1, dst);
    repeat (2000) tick();
    mem_wr_ready = 1'b0;
    repeat (200) tick();
    mem_wr_ready = 1'b1;
    wait_done("ovf", d0, 4700);
    chk("ovf_err_ovf", 32'(err_ovf), 32'd1);
    check_writes("ovf", dst, 1'b0);

    // Zero sectors: done quickly, no request
    d0 = done_cnt; r0 = rs_cnt;
    start_load($urandom, 16'd0, 16'h40);
    n = 0;
    while (!done && n < 3) begin
      tick();
      n++;
    end
    chk("zero_done", 32'(done), 32'd1);
    repeat (3) tick();
    chk("zero_no_req", 32'(rs_cnt - r0), 32'd0);
    chk("zero_busy", 32'(busy), 32'd0);

    // Start without init_done is ignored
    init_done = 1'b0;
    r0 = rs_cnt;
    start_load(32'h55, 16'd1, 16'h0);
    chk("noinit_busy_t1", 32'(busy), 32'd0);
    repeat (5) tick();
    chk("noinit_busy", 32'(busy), 32'd0);
    chk("noinit_no_req", 32'(rs_cnt - r0), 32'd0);
    init_done = 1'b1;

    // Reset in the middle of a transfer
    fill_random();
    start_load($urandom, 16'd2, 16'($urandom));
    repeat (1500) tick();
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_err_ovf", 32'(err_ovf), 32'd0);
    chk("arst_err_len", 32'(err_len), 32'd0);
    chk("arst_rd_start_en", 32'(rd_start_en), 32'd0);
    chk("arst_rd_sec_addr", rd_sec_addr, 32'd0);
    chk("arst_mem_wr_en", 32'(mem_wr_en), 32'd0);
    chk("arst_mem_wr_addr", 32'(mem_wr_addr), 32'd0);
    chk("arst_mem_wr_data", mem_wr_data, 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();
    wr_ptr = wd_q.size();

    // Single-sector load after reset
    fill_counting();
    build_expected(1);
    d0 = done_cnt; s0 = sec_q.size();
    start_load(32'h100, 16'd1, 16'h20);
    chk("post_sec_addr", rd_sec_addr, 32'h100);
    wait_done("post", d0, 4700);
    chk("post_sectors", 32'(sec_q.size() - s0), 32'd1);
    chk("post_first_word", wd_q[wr_ptr], 32'h03020100);
    check_writes("post", 16'h20, 1'b1);
    chk("post_err_len", 32'(err_len), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
